// File: rtl/traffic_ctrl_if.sv
// traffic_ctrl_if: the control and position bundle between the frame/game logic
// (master) and the traffic motion engine (slave). clk and reset stay plain ports
// on the modules.
//
// Handshake: there is no valid/ready pair. frame_tick and restart are
// single-cycle strobes that the master drives. Positions and moved are
// registered outputs that the slave drives. All length outputs are constants.
//
// Signals
//   frame_tick      master->slave  1-cycle pulse per frame
//   run             master->slave  1 = traffic moves, 0 = frozen
//   restart         master->slave  1-cycle pulse, reloads initial positions
//   level           master->slave  difficulty; step = level + 1 px
//   laneN_car0_x    slave->master  car0 left-edge x, N = 0..5
//   lane4_car1_x    slave->master  second lane-4 vehicle left-edge x
//   laneN_length    slave->master  vehicle length, constant
//   moved           slave->master  pulse: a vehicle moved on the last tick
interface traffic_ctrl_if;
  logic       frame_tick;
  logic       run;
  logic       restart;
  logic [1:0] level;
  logic [9:0] lane0_car0_x;
  logic [9:0] lane1_car0_x;
  logic [9:0] lane2_car0_x;
  logic [9:0] lane3_car0_x;
  logic [9:0] lane4_car0_x;
  logic [9:0] lane5_car0_x;
  logic [9:0] lane4_car1_x;
  logic [9:0] lane0_length;
  logic [9:0] lane1_length;
  logic [9:0] lane2_length;
  logic [9:0] lane3_length;
  logic [9:0] lane4_length;
  logic [9:0] lane5_length;
  logic       moved;

  modport master (
    output frame_tick, run, restart, level,
    input  lane0_car0_x, lane1_car0_x, lane2_car0_x, lane3_car0_x,
           lane4_car0_x, lane5_car0_x, lane4_car1_x,
           lane0_length, lane1_length, lane2_length, lane3_length,
           lane4_length, lane5_length, moved
  );

  modport slave (
    input  frame_tick, run, restart, level,
    output lane0_car0_x, lane1_car0_x, lane2_car0_x, lane3_car0_x,
           lane4_car0_x, lane5_car0_x, lane4_car1_x,
           lane0_length, lane1_length, lane2_length, lane3_length,
           lane4_length, lane5_length, moved
  );
endinterface

// File: rtl/traffic_ctrl.sv
// traffic_ctrl: motion engine for the road section. It owns the left-edge x of
// every vehicle in lanes 0-5. Lane 4 carries two vehicles and every other lane
// carries one. Each lane has a frame counter. On every PER-th active frame tick
// the lane's vehicles move by (level+1) px and wrap around the playfield.
//
// Ports
//   clk    in  system/pixel clock
//   reset  in  synchronous, active-high
//   tc     traffic_ctrl_if.slave (frame_tick, run, restart, level in;
//          lane x positions, lengths and moved out)
//
// Internal car index 0..5 = laneN car0. Index 6 = lane4 car1.
module traffic_ctrl #(
  parameter logic [9:0] X_OFFSET_LEFT  = 10'd96,
  parameter logic [9:0] X_OFFSET_RIGHT = 10'd544,
  parameter logic [9:0] LANE0_LEN = 10'd32,
  parameter logic [9:0] LANE1_LEN = 10'd96,
  parameter logic [9:0] LANE2_LEN = 10'd32,
  parameter logic [9:0] LANE3_LEN = 10'd64,
  parameter logic [9:0] LANE4_LEN = 10'd32,
  parameter logic [9:0] LANE5_LEN = 10'd96,
  parameter logic       LANE0_DIR = 1'b0,
  parameter logic       LANE1_DIR = 1'b1,
  parameter logic       LANE2_DIR = 1'b0,
  parameter logic       LANE3_DIR = 1'b1,
  parameter logic       LANE4_DIR = 1'b0,
  parameter logic       LANE5_DIR = 1'b1,
  parameter logic [3:0] LANE0_PER = 4'd4,
  parameter logic [3:0] LANE1_PER = 4'd2,
  parameter logic [3:0] LANE2_PER = 4'd3,
  parameter logic [3:0] LANE3_PER = 4'd2,
  parameter logic [3:0] LANE4_PER = 4'd1,
  parameter logic [3:0] LANE5_PER = 4'd3,
  parameter logic [9:0] LANE0_X0 = 10'd400,
  parameter logic [9:0] LANE1_X0 = 10'd96,
  parameter logic [9:0] LANE2_X0 = 10'd300,
  parameter logic [9:0] LANE3_X0 = 10'd200,
  parameter logic [9:0] LANE4_X0 = 10'd150,
  parameter logic [9:0] LANE5_X0 = 10'd250,
  parameter logic [9:0] LANE4_GAP = 10'd224
) (
  input  logic clk,
  input  logic reset,
  traffic_ctrl_if.slave tc
);

  localparam int N_CAR  = 7;
  localparam int N_LANE = 6;

  localparam logic [9:0] CAR_X0 [N_CAR] = '{LANE0_X0, LANE1_X0, LANE2_X0, LANE3_X0,
                                            LANE4_X0, LANE5_X0, LANE4_X0 + LANE4_GAP};
  localparam logic [9:0] CAR_LEN [N_CAR] = '{LANE0_LEN, LANE1_LEN, LANE2_LEN, LANE3_LEN,
                                             LANE4_LEN, LANE5_LEN, LANE4_LEN};
  localparam logic CAR_DIR [N_CAR] = '{LANE0_DIR, LANE1_DIR, LANE2_DIR, LANE3_DIR,
                                       LANE4_DIR, LANE5_DIR, LANE4_DIR};
  localparam int CAR_LANE [N_CAR] = '{0, 1, 2, 3, 4, 5, 4};
  localparam logic [3:0] LANE_PER_M1 [N_LANE] = '{LANE0_PER - 4'd1, LANE1_PER - 4'd1,
                                                  LANE2_PER - 4'd1, LANE3_PER - 4'd1,
                                                  LANE4_PER - 4'd1, LANE5_PER - 4'd1};

  logic [9:0] r_x   [N_CAR];
  logic [3:0] r_cnt [N_LANE];
  logic       r_moved;

  logic [9:0]        w_s;
  logic [N_LANE-1:0] w_step;
  logic [9:0]        w_nx [N_CAR];

  always_comb begin
    w_s = {8'd0, tc.level} + 10'd1;
    for (int l = 0; l < N_LANE; l++) begin
      w_step[l] = (r_cnt[l] == LANE_PER_M1[l]);
    end
    for (int c = 0; c < N_CAR; c++) begin
      w_nx[c] = r_x[c];
      if (CAR_DIR[c]) begin
        if (r_x[c] + w_s >= X_OFFSET_RIGHT) w_nx[c] = X_OFFSET_LEFT - CAR_LEN[c];
        else                                w_nx[c] = r_x[c] + w_s;
      end else begin
        // The wrap test is done before the subtraction, so x - S never underflows.
        if (r_x[c] + CAR_LEN[c] <= X_OFFSET_LEFT + w_s) w_nx[c] = X_OFFSET_RIGHT;
        else                                            w_nx[c] = r_x[c] - w_s;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || tc.restart) begin
      for (int c = 0; c < N_CAR; c++)  r_x[c]   <= CAR_X0[c];
      for (int l = 0; l < N_LANE; l++) r_cnt[l] <= 4'd0;
      r_moved <= 1'b0;
    end else if (tc.frame_tick && tc.run) begin
      for (int l = 0; l < N_LANE; l++) begin
        r_cnt[l] <= w_step[l] ? 4'd0 : r_cnt[l] + 4'd1;
      end
      for (int c = 0; c < N_CAR; c++) begin
        if (w_step[CAR_LANE[c]]) r_x[c] <= w_nx[c];
      end
      r_moved <= |w_step;
    end else begin
      r_moved <= 1'b0;
    end
  end

  assign tc.lane0_car0_x = r_x[0];
  assign tc.lane1_car0_x = r_x[1];
  assign tc.lane2_car0_x = r_x[2];
  assign tc.lane3_car0_x = r_x[3];
  assign tc.lane4_car0_x = r_x[4];
  assign tc.lane5_car0_x = r_x[5];
  assign tc.lane4_car1_x = r_x[6];
  assign tc.lane0_length = LANE0_LEN;
  assign tc.lane1_length = LANE1_LEN;
  assign tc.lane2_length = LANE2_LEN;
  assign tc.lane3_length = LANE3_LEN;
  assign tc.lane4_length = LANE4_LEN;
  assign tc.lane5_length = LANE5_LEN;
  assign tc.moved        = r_moved;

endmodule

// File: tb/tb_traffic_ctrl.sv
module tb_traffic_ctrl;

  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  traffic_ctrl_if if_a ();
  traffic_ctrl_if if_b ();

  // Default instance, and a second one set up for the playfield wrap cases.
  traffic_ctrl u_dut (
    .clk   (clk),
    .reset (reset),
    .tc    (if_a.slave)
  );

  traffic_ctrl #(
    .LANE0_X0  (10'd65),
    .LANE0_PER (4'd1),
    .LANE1_X0  (10'd543),
    .LANE1_PER (4'd1)
  ) u_dut_w (
    .clk   (clk),
    .reset (reset),
    .tc    (if_b.slave)
  );

  // Car index 0..5 = laneN car0. Index 6 = lane4 car1.
  logic [9:0] a_x [2][7];
  logic       a_moved [2];
  always_comb begin
    a_x[0][0] = if_a.lane0_car0_x; a_x[0][1] = if_a.lane1_car0_x;
    a_x[0][2] = if_a.lane2_car0_x; a_x[0][3] = if_a.lane3_car0_x;
    a_x[0][4] = if_a.lane4_car0_x; a_x[0][5] = if_a.lane5_car0_x;
    a_x[0][6] = if_a.lane4_car1_x;
    a_x[1][0] = if_b.lane0_car0_x; a_x[1][1] = if_b.lane1_car0_x;
    a_x[1][2] = if_b.lane2_car0_x; a_x[1][3] = if_b.lane3_car0_x;
    a_x[1][4] = if_b.lane4_car0_x; a_x[1][5] = if_b.lane5_car0_x;
    a_x[1][6] = if_b.lane4_car1_x;
    a_moved[0] = if_a.moved;
    a_moved[1] = if_b.moved;
  end

  // Reference model: the vehicle geometry and the count of active ticks since
  // the last (re)start. A lane moves on every tick whose count is a multiple
  // of its period.
  int car_len  [7] = '{32, 96, 32, 64, 32, 96, 32};
  int car_dir  [7] = '{0, 1, 0, 1, 0, 1, 0};
  int car_lane [7] = '{0, 1, 2, 3, 4, 5, 4};
  int per   [2][6] = '{'{4, 2, 3, 2, 1, 3}, '{1, 1, 3, 2, 1, 3}};
  int x0    [2][7] = '{'{400, 96, 300, 200, 150, 250, 374},
                       '{65, 543, 300, 200, 150, 250, 374}};
  int m_x   [2][7];
  int m_ticks;
  bit m_moved;

  int n_cmp;
  int n_err;

  function automatic int move_x(int x, int len, int dir, int s);
    if (dir == 1) return (x + s >= 544) ? 96 - len : x + s;
    else          return (x + len <= 96 + s) ? 544 : x - s;
  endfunction

  task automatic model_update(input bit rst, input bit tick, input bit rn,
                              input bit rs, input int lv);
    if (rst || rs) begin
      m_x = x0;
      m_ticks = 0;
      m_moved = 0;
    end else if (tick && rn) begin
      m_ticks++;
      m_moved = 0;
      for (int d = 0; d < 2; d++)
        for (int c = 0; c < 7; c++)
          if (m_ticks % per[d][car_lane[c]] == 0) begin
            m_x[d][c] = move_x(m_x[d][c], car_len[c], car_dir[c], lv + 1);
            m_moved = 1;
          end
    end else begin
      m_moved = 0;
    end
  endtask

  // Drive one clock cycle. Inputs change on the falling edge, and the model
  // follows the rising edge. The caller samples 1 time unit after that edge.
  task automatic cyc(input bit rst, input bit tick, input bit rn, input bit rs, input int lv);
    @(negedge clk);
    reset = rst;
    if_a.frame_tick = tick; if_b.frame_tick = tick;
    if_a.run = rn;          if_b.run = rn;
    if_a.restart = rs;      if_b.restart = rs;
    if_a.level = 2'(lv);    if_b.level = 2'(lv);
    @(posedge clk);
    #1;
    model_update(rst, tick, rn, rs, lv);
  endtask

  task automatic test_reset;
    cyc(1, 0, 0, 0, 0);
    // Lengths are constants and must already be valid while reset is high.
    n_cmp++; if (if_a.lane3_length !== 10'd64) begin n_err++; $display("FAIL reset_len3 got %0d exp 64", if_a.lane3_length); end
    n_cmp++; if (if_a.lane1_length !== 10'd96) begin n_err++; $display("FAIL reset_len1 got %0d exp 96", if_a.lane1_length); end
    n_cmp++; if (if_a.lane0_length !== 10'd32) begin n_err++; $display("FAIL reset_len0 got %0d exp 32", if_a.lane0_length); end
    cyc(1, 1, 1, 0, 3);
    n_cmp++; if (if_a.lane0_car0_x !== 10'd400) begin n_err++; $display("FAIL reset_l0 got %0d exp 400", if_a.lane0_car0_x); end
    n_cmp++; if (if_a.lane1_car0_x !== 10'd96) begin n_err++; $display("FAIL reset_l1 got %0d exp 96", if_a.lane1_car0_x); end
    n_cmp++; if (if_a.lane4_car1_x !== 10'd374) begin n_err++; $display("FAIL reset_l4c1 got %0d exp 374", if_a.lane4_car1_x); end
    n_cmp++; if (if_a.moved !== 1'b0) begin n_err++; $display("FAIL reset_moved got %0b exp 0", if_a.moved); end
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 7; c++) begin
        n_cmp++;
        if (a_x[d][c] !== 10'(m_x[d][c])) begin n_err++; $display("FAIL reset_x dut%0d car%0d got %0d exp %0d", d, c, a_x[d][c], m_x[d][c]); end
      end
    cyc(0, 0, 1, 0, 0);
  endtask

  task automatic test_period;
    cyc(0, 1, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    n_cmp++; if (if_a.lane1_car0_x !== 10'd97) begin n_err++; $display("FAIL period_l1 got %0d exp 97", if_a.lane1_car0_x); end
    n_cmp++; if (if_a.lane3_car0_x !== 10'd201) begin n_err++; $display("FAIL period_l3 got %0d exp 201", if_a.lane3_car0_x); end
    n_cmp++; if (if_a.lane4_car0_x !== 10'd148) begin n_err++; $display("FAIL period_l4c0 got %0d exp 148", if_a.lane4_car0_x); end
    n_cmp++; if (if_a.lane4_car1_x !== 10'd372) begin n_err++; $display("FAIL period_l4c1 got %0d exp 372", if_a.lane4_car1_x); end
    n_cmp++; if (if_a.lane0_car0_x !== 10'd400) begin n_err++; $display("FAIL period_l0 got %0d exp 400", if_a.lane0_car0_x); end
    n_cmp++; if (if_a.lane2_car0_x !== 10'd300) begin n_err++; $display("FAIL period_l2_early got %0d exp 300", if_a.lane2_car0_x); end
    n_cmp++; if (if_a.moved !== 1'b1) begin n_err++; $display("FAIL period_moved got %0b exp 1", if_a.moved); end
    cyc(0, 0, 1, 0, 0);
    n_cmp++; if (if_a.moved !== 1'b0) begin n_err++; $display("FAIL period_moved_pulse got %0b exp 0", if_a.moved); end
    cyc(0, 1, 1, 0, 0);
    n_cmp++; if (if_a.lane2_car0_x !== 10'd299) begin n_err++; $display("FAIL period_l2 got %0d exp 299", if_a.lane2_car0_x); end
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 7; c++) begin
        n_cmp++;
        if (a_x[d][c] !== 10'(m_x[d][c])) begin n_err++; $display("FAIL period_x dut%0d car%0d got %0d exp %0d", d, c, a_x[d][c], m_x[d][c]); end
      end
  endtask

  task automatic test_wrap;
    cyc(0, 0, 1, 1, 0);
    cyc(0, 1, 1, 0, 0);
    n_cmp++; if (if_b.lane1_car0_x !== 10'd0) begin n_err++; $display("FAIL wrap_right got %0d exp 0", if_b.lane1_car0_x); end
    n_cmp++; if (if_b.lane0_car0_x !== 10'd544) begin n_err++; $display("FAIL wrap_left got %0d exp 544", if_b.lane0_car0_x); end
    cyc(0, 1, 1, 0, 0);
    n_cmp++; if (if_b.lane1_car0_x !== 10'd1) begin n_err++; $display("FAIL wrap_right_next got %0d exp 1", if_b.lane1_car0_x); end
    n_cmp++; if (if_b.lane0_car0_x !== 10'd543) begin n_err++; $display("FAIL wrap_left_next got %0d exp 543", if_b.lane0_car0_x); end
  endtask

  task automatic test_freeze_level;
    logic [9:0] snap [2][7];
    snap = a_x;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, 0, 0, $urandom_range(0, 3));
      n_cmp++; if (a_moved[0] !== 1'b0) begin n_err++; $display("FAIL freeze_moved got %0b exp 0", a_moved[0]); end
    end
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 7; c++) begin
        n_cmp++;
        if (a_x[d][c] !== snap[d][c]) begin n_err++; $display("FAIL freeze_x dut%0d car%0d got %0d exp %0d", d, c, a_x[d][c], snap[d][c]); end
      end
    cyc(0, 1, 1, 0, 3);
    n_cmp++; if (if_a.lane4_car0_x !== snap[0][4] - 10'd4) begin n_err++; $display("FAIL level_l4 got %0d exp %0d", if_a.lane4_car0_x, snap[0][4] - 10'd4); end
    n_cmp++; if (if_b.lane1_car0_x !== snap[1][1] + 10'd4) begin n_err++; $display("FAIL level_w_l1 got %0d exp %0d", if_b.lane1_car0_x, snap[1][1] + 10'd4); end
    cyc(0, 1, 1, 0, 3);
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 7; c++) begin
        n_cmp++;
        if (a_x[d][c] !== 10'(m_x[d][c])) begin n_err++; $display("FAIL level_x dut%0d car%0d got %0d exp %0d", d, c, a_x[d][c], m_x[d][c]); end
      end
  endtask

  task automatic test_restart;
    for (int i = 0; i < 5; i++) cyc(0, 1, 1, 0, 1);
    cyc(0, 1, 1, 1, 3);
    n_cmp++; if (if_a.moved !== 1'b0) begin n_err++; $display("FAIL restart_moved got %0b exp 0", if_a.moved); end
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 7; c++) begin
        n_cmp++;
        if (a_x[d][c] !== 10'(x0[d][c])) begin n_err++; $display("FAIL restart_x dut%0d car%0d got %0d exp %0d", d, c, a_x[d][c], x0[d][c]); end
      end
    // The counters must be back at zero, so lane 0 of dut 0 moves on the fourth tick only.
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 0);
    n_cmp++; if (if_a.lane0_car0_x !== 10'd400) begin n_err++; $display("FAIL restart_cnt_hold got %0d exp 400", if_a.lane0_car0_x); end
    cyc(0, 1, 1, 0, 0);
    n_cmp++; if (if_a.lane0_car0_x !== 10'd399) begin n_err++; $display("FAIL restart_cnt_step got %0d exp 399", if_a.lane0_car0_x); end
  endtask

  task automatic test_random;
    for (int i = 0; i < 600; i++) begin
      cyc(0, $urandom_range(0, 2) != 0, $urandom_range(0, 4) != 0,
          $urandom_range(0, 59) == 0, $urandom_range(0, 3));
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < 7; c++) begin
          n_cmp++;
          if (a_x[d][c] !== 10'(m_x[d][c])) begin n_err++; $display("FAIL random_x cyc%0d dut%0d car%0d got %0d exp %0d", i, d, c, a_x[d][c], m_x[d][c]); end
        end
        n_cmp++;
        if (a_moved[d] !== m_moved) begin n_err++; $display("FAIL random_moved cyc%0d dut%0d got %0b exp %0b", i, d, a_moved[d], m_moved); end
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    if_a.frame_tick = 1'b0; if_b.frame_tick = 1'b0;
    if_a.run = 1'b0;        if_b.run = 1'b0;
    if_a.restart = 1'b0;    if_b.restart = 1'b0;
    if_a.level = 2'd0;      if_b.level = 2'd0;
    test_reset;
    test_period;
    test_wrap;
    test_freeze_level;
    test_restart;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
